// File: rtl/agc_io_channels.sv
// I/O channel unit for the AGC core: output latches, keycode FIFO, prescaled timer,
// sticky status flags and a synchronized discrete-input word behind 3-bit selects.
module agc_io_channels #(
  parameter int TICK_DIV  = 1000,
  parameter int KEY_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  IO_read_sel,
  output logic [14:0] IO_read_data,
  input  logic [2:0]  IO_write_sel,
  input  logic [14:0] IO_write_data,
  input  logic        IO_write_en,
  input  logic        stall,
  input  logic [4:0]  key_code,
  input  logic        key_strobe,
  input  logic [14:0] in0,
  output logic [14:0] out0,
  output logic [14:0] out1,
  output logic        out0_strobe,
  output logic        timer_irq
);

  localparam int PW  = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);
  localparam logic [PW:0]    DEPTH   = (PW + 1)'(KEY_DEPTH);

  logic [14:0] readData_q, readData_d;
  logic [14:0] out0_q, out0_d;
  logic [14:0] out1_q, out1_d;
  logic        strobe_q, strobe_d;
  logic        irq_q, irq_d;
  logic [14:0] timer_q, timer_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW:0]   count_q, count_d;
  logic        tmrOvf_q, tmrOvf_d;
  logic        keyOvf_q, keyOvf_d;
  logic [14:0] sync1_q, sync2_q;
  logic [4:0]  mem_q [KEY_DEPTH];

  logic        wrCh0, wrCh1, wrCh2, wrCh3, wrCh4;
  logic        keyValid, pop, push, keyOvfSet, wrap;
  logic [4:0]  keyHead;
  logic [3:0]  countWide;
  logic [14:0] readMux;

  assign wrCh0 = IO_write_en && (IO_write_sel == 3'd0);
  assign wrCh1 = IO_write_en && (IO_write_sel == 3'd1);
  assign wrCh2 = IO_write_en && (IO_write_sel == 3'd2);
  assign wrCh3 = IO_write_en && (IO_write_sel == 3'd3);
  assign wrCh4 = IO_write_en && (IO_write_sel == 3'd4);

  assign keyValid  = (count_q != '0);
  assign keyHead   = keyValid ? mem_q[rdPtr_q] : 5'd0;
  assign countWide = 4'(count_q);
  assign pop       = !stall && (IO_read_sel == 3'd2) && keyValid;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push      = key_strobe && !wrCh2 && ((count_q != DEPTH) || pop);
  assign keyOvfSet = key_strobe && !wrCh2 && (count_q == DEPTH) && !pop;

  always_comb begin
    readMux = 15'd0;
    case (IO_read_sel)
      3'd0: readMux = out0_q;
      3'd1: readMux = out1_q;
      3'd2: readMux = {9'd0, keyValid, keyHead};
      3'd3: readMux = timer_q;
      3'd4: readMux = {9'd0, countWide[2:0], tmrOvf_q, keyOvf_q, keyValid};
      3'd5: readMux = sync2_q;
      default: readMux = 15'd0;
    endcase
  end

  always_comb begin
    readData_d = stall ? readData_q : readMux;
    out0_d     = wrCh0 ? IO_write_data : out0_q;
    out1_d     = wrCh1 ? IO_write_data : out1_q;
    strobe_d   = wrCh0;

    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrCh2) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      if (push && !pop)      count_d = count_q + (PW + 1)'(1);
      else if (pop && !push) count_d = count_q - (PW + 1)'(1);
    end

    // A load through channel 3 overrides a tick landing on the same edge.
    wrap    = 1'b0;
    timer_d = timer_q;
    presc_d = presc_q + PSW'(1);
    if (wrCh3) begin
      timer_d = IO_write_data;
      presc_d = '0;
    end else if (presc_q == PS_LAST) begin
      presc_d = '0;
      timer_d = timer_q + 15'd1;
      wrap    = (timer_q == 15'h7FFF);
    end
    irq_d = wrap;

    tmrOvf_d = wrap      || (tmrOvf_q && !(wrCh4 && IO_write_data[2]));
    keyOvf_d = keyOvfSet || (keyOvf_q && !(wrCh4 && IO_write_data[1]));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readData_q <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      strobe_q   <= 1'b0;
      irq_q      <= 1'b0;
      timer_q    <= '0;
      presc_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      tmrOvf_q   <= 1'b0;
      keyOvf_q   <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      readData_q <= readData_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      strobe_q   <= strobe_d;
      irq_q      <= irq_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      tmrOvf_q   <= tmrOvf_d;
      keyOvf_q   <= keyOvf_d;
      sync1_q    <= in0;
      sync2_q    <= sync1_q;
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clock) begin
    if (push) mem_q[wrPtr_q] <= key_code;
  end

  assign IO_read_data = readData_q;
  assign out0         = out0_q;
  assign out1         = out1_q;
  assign out0_strobe  = strobe_q;
  assign timer_irq    = irq_q;

endmodule

// File: tb/tb_agc_io_channels.sv
// Self-checking bench for agc_io_channels: a transaction-level model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_agc_io_channels;
  localparam int TD = 4;
  localparam int KD = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  IO_read_sel;
  logic [14:0] IO_read_data;
  logic [2:0]  IO_write_sel;
  logic [14:0] IO_write_data;
  logic        IO_write_en;
  logic        stall;
  logic [4:0]  key_code;
  logic        key_strobe;
  logic [14:0] in0;
  logic [14:0] out0, out1;
  logic        out0_strobe, timer_irq;

  int checks = 0;
  int errors = 0;

  agc_io_channels #(.TICK_DIV(TD), .KEY_DEPTH(KD)) dut (
    .clock(clock), .reset_n(reset_n),
    .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
    .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data), .IO_write_en(IO_write_en),
    .stall(stall), .key_code(key_code), .key_strobe(key_strobe), .in0(in0),
    .out0(out0), .out1(out1), .out0_strobe(out0_strobe), .timer_irq(timer_irq)
  );

  always #5 clock = ~clock;

  // Model state
  bit          mOn = 0;
  logic [14:0] mRead = 0, mOut0 = 0, mOut1 = 0, syncA = 0, syncB = 0;
  bit          mStrobe = 0, mIrq = 0, mTmrOvf = 0, mKeyOvf = 0;
  int          tmrBase = 0, tmrEdges = 0;
  logic [4:0]  keyQ[$];

  function automatic logic [14:0] timerNow();
    return 15'((tmrBase + tmrEdges / TD) % 32768);
  endfunction

  task automatic checkOutput(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    bit keySet, doPop;
    logic [14:0] wd;
    if (!reset_n) begin
      mOn = 1; mRead = 0; mOut0 = 0; mOut1 = 0; mStrobe = 0; mIrq = 0;
      tmrBase = 0; tmrEdges = 0; mTmrOvf = 0; mKeyOvf = 0; keyQ.delete();
      syncA = 0; syncB = 0;
    end else begin
      wd = IO_write_data;
      keySet = 0;
      if (!stall) begin
        case (IO_read_sel)
          3'd0: mRead = mOut0;
          3'd1: mRead = mOut1;
          3'd2: mRead = (keyQ.size() > 0) ? {9'd0, 1'b1, keyQ[0]} : 15'd0;
          3'd3: mRead = timerNow();
          3'd4: mRead = {9'd0, 3'(keyQ.size()), mTmrOvf, mKeyOvf, keyQ.size() != 0};
          3'd5: mRead = syncB;
          default: mRead = 15'd0;
        endcase
      end
      doPop = !stall && IO_read_sel == 3'd2 && keyQ.size() > 0;
      mStrobe = IO_write_en && IO_write_sel == 3'd0;
      if (mStrobe) mOut0 = wd;
      if (IO_write_en && IO_write_sel == 3'd1) mOut1 = wd;
      if (IO_write_en && IO_write_sel == 3'd3) begin
        tmrBase = int'(wd); tmrEdges = 0; mIrq = 0;
      end else begin
        tmrEdges++;
        mIrq = (tmrEdges % TD == 0) && (timerNow() == 15'd0);
      end
      if (IO_write_en && IO_write_sel == 3'd2) keyQ.delete();
      else begin
        if (doPop) void'(keyQ.pop_front());
        if (key_strobe) begin
          if (keyQ.size() < KD) keyQ.push_back(key_code);
          else keySet = 1;
        end
      end
      if (mIrq) mTmrOvf = 1;
      else if (IO_write_en && IO_write_sel == 3'd4 && wd[2]) mTmrOvf = 0;
      if (keySet) mKeyOvf = 1;
      else if (IO_write_en && IO_write_sel == 3'd4 && wd[1]) mKeyOvf = 0;
      syncB = syncA; syncA = in0;
    end
  end

  always @(negedge clock) begin
    if (mOn) begin
      checkOutput("read_data", IO_read_data, mRead);
      checkOutput("out0", out0, mOut0);
      checkOutput("out1", out1, mOut1);
      checkOutput("out0_strobe", 15'(out0_strobe), 15'(mStrobe));
      checkOutput("timer_irq", 15'(timer_irq), 15'(mIrq));
    end
  end

  task automatic applyStimulus(input logic [2:0] rsel, input logic st, input logic we,
                               input logic [2:0] wsel, input logic [14:0] wdata,
                               input logic ks, input logic [4:0] kc);
    IO_read_sel = rsel; stall = st; IO_write_en = we; IO_write_sel = wsel;
    IO_write_data = wdata; key_strobe = ks; key_code = kc;
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input logic [2:0] rsel);
    applyStimulus(rsel, 0, 0, 3'd0, 15'd0, 0, 5'd0);
  endtask

  task automatic pushKey(input logic [4:0] kc);
    applyStimulus(3'd0, 0, 0, 3'd0, 15'd0, 1, kc);
  endtask

  task automatic writeCh(input logic [2:0] wsel, input logic [14:0] wdata, input logic [2:0] rsel);
    applyStimulus(rsel, 0, 1, wsel, wdata, 0, 5'd0);
  endtask

  initial begin
    logic [4:0] keys[5];
    logic [14:0] keyReads[5];
    keys = '{5'd3, 5'd7, 5'd1, 5'd9, 5'd5};
    keyReads = '{15'h0023, 15'h0027, 15'h0021, 15'h0029, 15'h0000};
    reset_n = 0; in0 = 0;
    IO_read_sel = 0; stall = 0; IO_write_en = 0; IO_write_sel = 0;
    IO_write_data = 0; key_strobe = 0; key_code = 0;
    idle(3'd0);
    idle(3'd0);
    reset_n = 1;
    checkOutput("reset_read", IO_read_data, 15'h0000);
    checkOutput("reset_out0", out0, 15'h0000);

    for (int i = 0; i < 8; i++) begin
      idle(3'(i));
      checkOutput("idle_read", IO_read_data, 15'h0000);
    end

    writeCh(3'd0, 15'h2A5A, 3'd0);
    checkOutput("wr_same_cycle_read", IO_read_data, 15'h0000);
    checkOutput("wr_out0", out0, 15'h2A5A);
    checkOutput("wr_strobe", 15'(out0_strobe), 15'h0001);
    idle(3'd0);
    checkOutput("rd_ch0", IO_read_data, 15'h2A5A);
    checkOutput("strobe_drop", 15'(out0_strobe), 15'h0000);
    writeCh(3'd1, 15'h1234, 3'd0);
    idle(3'd1);
    checkOutput("rd_ch1", IO_read_data, 15'h1234);

    for (int i = 0; i < 5; i++) pushKey(keys[i]);
    idle(3'd4);
    checkOutput("status_full_ovf", IO_read_data, 15'h0023);
    for (int i = 0; i < 5; i++) begin
      idle(3'd2);
      checkOutput("key_pop", IO_read_data, keyReads[i]);
    end

    writeCh(3'd4, 15'h0002, 3'd0);
    for (int i = 1; i <= 4; i++) pushKey(5'(i));
    applyStimulus(3'd2, 0, 0, 3'd0, 15'd0, 1, 5'd6);
    checkOutput("pushpop_full_read", IO_read_data, 15'h0021);
    idle(3'd4);
    checkOutput("pushpop_full_status", IO_read_data, 15'h0021);
    writeCh(3'd2, 15'h0000, 3'd0);

    pushKey(5'h0A);
    pushKey(5'h0B);
    idle(3'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd2, 1, 0, 3'd0, 15'd0, 0, 5'd0);
      checkOutput("stall_hold", IO_read_data, 15'h2A5A);
    end
    idle(3'd2);
    checkOutput("stall_release_pop", IO_read_data, 15'h002A);
    idle(3'd4);
    checkOutput("stall_count", IO_read_data, 15'h0009);

    writeCh(3'd3, 15'h7FFE, 3'd0);
    for (int i = 1; i <= 8; i++) begin
      idle(3'd3);
      if (i == 4) checkOutput("timer_pre_tick", IO_read_data, 15'h7FFE);
      if (i == 5) checkOutput("timer_tick", IO_read_data, 15'h7FFF);
    end
    checkOutput("timer_wrap_irq", 15'(timer_irq), 15'h0001);
    idle(3'd4);
    checkOutput("tmr_ovf_set", IO_read_data, 15'h000D);
    checkOutput("irq_one_cycle", 15'(timer_irq), 15'h0000);
    writeCh(3'd4, 15'h0004, 3'd4);
    idle(3'd4);
    checkOutput("tmr_ovf_clear", IO_read_data, 15'h0009);

    in0 = 15'h1555;
    idle(3'd5);
    idle(3'd5);
    checkOutput("in0_not_yet", IO_read_data, 15'h0000);
    idle(3'd5);
    checkOutput("in0_sync", IO_read_data, 15'h1555);

    applyStimulus(3'd0, 0, 1, 3'd2, 15'd0, 1, 5'h11);
    idle(3'd4);
    checkOutput("clear_beats_push", IO_read_data, 15'h0000);

    pushKey(5'd1); pushKey(5'd2); pushKey(5'd3);
    idle(3'd3);
    reset_n = 0;
    idle(3'd0);
    reset_n = 1;
    checkOutput("rst_mid_read", IO_read_data, 15'h0000);
    checkOutput("rst_mid_out0", out0, 15'h0000);
    idle(3'd2);
    checkOutput("rst_fifo_empty", IO_read_data, 15'h0000);
    idle(3'd4);
    checkOutput("rst_status", IO_read_data, 15'h0000);
    idle(3'd3);
    checkOutput("rst_timer", IO_read_data, 15'h0000);

    for (int i = 0; i < 300; i++) begin
      in0 = 15'($urandom);
      applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 0) ? 15'h7FFF - 15'($urandom_range(0, 5)) : 15'($urandom),
                    ($urandom_range(0, 1) == 0), 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/agc_io_channels.md
# agc_io_channels

I/O channel unit for the AGC core. It is the peer the core drives through its `IO_*` port group and the counterpart of the ROM/RAM blocks in the top-level bench. It provides eight 15-bit channels selected by 3-bit read/write selects:
- two output latches for the DSKY/display pins,
- a keycode FIFO fed by the keyboard strobe,
- a free-running prescaled timer,
- a sticky status word,
- a synchronized discrete-input word.

Read data is registered with the same 1-cycle, stall-held latency as the ROM/RAM ports.

## Interface
Parameters:
- TICK_DIV, 1000: clock cycles per timer increment; legal range ≥2.
- KEY_DEPTH, 4: keycode FIFO entries; power of 2, 2..8.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- IO_read_sel  in  3  channel to read.
- IO_read_data  out  15  registered read data.
- IO_write_sel  in  3  channel to write.
- IO_write_data  in  15  write data.
- IO_write_en  in  1  write strobe, one write per asserted cycle.
- stall  in  1  core stall; holds the read register and blocks read side effects.
- key_code  in  5  keycode from the keyboard block.
- key_strobe  in  1  single-cycle push of key_code.
- in0  in  15  asynchronous discrete inputs.
- out0  out  15  channel 0 latch.
- out1  out  15  channel 1 latch.
- out0_strobe  out  1  one-cycle pulse after each write to channel 0.
- timer_irq  out  1  one-cycle pulse when the timer wraps.

## Operation
Channel map (R = read effect, W = write effect):
- 0 OUT0: R returns the latch; W loads out0 and pulses out0_strobe.
- 1 OUT1: R returns the latch; W loads out1.
- 2 KEY:
  - R returns {9'b0, valid, code}, where valid=1 iff the FIFO is non-empty and code is the head entry (0 if empty).
  - R pops the FIFO at that edge if non-empty and stall=0.
  - W with any data clears the FIFO.
- 3 TIME: R returns the 15-bit counter; W loads the counter and zeroes the prescaler.
- 4 STATUS:
  - R returns {9'b0, count[2:0], tmr_ovf, key_ovf, nonempty}.
  - W is write-1-to-clear on bits 2 (tmr_ovf) and 1 (key_ovf); other bits are ignored.
- 5 IN0: R returns in0 after a 2-flop synchronizer. W is ignored.
- 6, 7: R returns 0; W is ignored.

Key FIFO:
- A push on key_strobe when full drops the key and sets sticky key_ovf.
- Push and pop in the same cycle: both happen; count is unchanged. When full, a pop frees a slot, so no overflow is flagged.
- Push and pop while empty: the pop is a no-op and the push is stored.
- Clear (W ch2) in the same cycle as a push: clear wins; the push is dropped and key_ovf is not set.
- Pointers wrap modulo KEY_DEPTH.

Timer:
- The prescaler counts 0..TICK_DIV-1.
- At TICK_DIV-1 the prescaler returns to 0 and the counter increments (unsigned, wraps 0x7FFF→0).
- On wrap: set sticky tmr_ovf and pulse timer_irq.
- W ch3 in the same cycle as a tick: the write wins; no increment, no irq.

Sticky flags:
- A set event and a W1C clear in the same cycle: set wins.

Writes:
- Writes are not gated by stall.
- A read and a write to the same channel in one cycle: read returns the pre-write value.

## Timing
Reset (reset_n=0 at an edge) forces these to 0:
- IO_read_data, out0, out1, out0_strobe, timer_irq
- the counter and prescaler
- FIFO pointers and count
- flags
- synchronizer flops

Reset mid-operation discards FIFO contents and any pending write.

Read path:
- At edge N with stall=0, IO_read_data captures the channel selected by IO_read_sel at edge N; it is valid after edge N.
- With stall=1, IO_read_data holds, no pop occurs, and the selection is ignored.

Write path:
- A write sampled at edge N is visible on out0/out1 and on reads sampled at edge N+1 or later.
- out0_strobe is high for the cycle after edge N.

Timer:
- After reset, or a write to ch3, the first increment occurs at the TICK_DIV-th edge.
- timer_irq is high for the cycle following the wrapping edge.

in0:
- A change is visible in a ch5 read sampled 2 edges after it is setup-captured.

## Test plan
- Reset, then read all 8 channels with no other stimulus -> every read returns 0x0000; out0, out1 and both strobes stay 0.
- Write 0x2A5A to ch0, then read ch0 -> out0=0x2A5A, out0_strobe high exactly 1 cycle, read returns 0x2A5A; same read/write cycle returns the old value 0.
- Push keys 3,7,1,9,5 (KEY_DEPTH=4) -> STATUS=0x0023 (count=4, key_ovf, nonempty); four ch2 reads return 0x0023, 0x0027, 0x0021, 0x0029, fifth returns 0; push+pop when full -> no overflow.
- Hold stall=1 over a ch2 read with 2 keys queued -> IO_read_data unchanged, count stays 2; release -> head popped once.
- TICK_DIV=4, write 0x7FFE to ch3 -> 0x7FFF after 4 cycles, 0 after 8 with timer_irq 1-cycle pulse, tmr_ovf=1; write 0x0004 to ch4 -> tmr_ovf cleared.
- Assert reset_n=0 for 1 cycle with 3 keys queued and the timer running -> all state 0, FIFO empty; reads return 0.
